alu_issue_stage: RTL and testbench

Upstream issue stage for the 8-bit combinational ALU. It buffers incoming operation commands (A, B, 3-bit select) in a small FIFO and drives them one at a time onto registered ALU operand and select lines. One cycle later it captures the ALU result and zero flag. Each result is then presented on a valid/ready output handshake, so that the ALU can sit between producer and consumer logic that stalls.

---
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 tb/tb_alu_issue_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage for the 8-bit combinational ALU: FIFO-buffered commands, registered
// operand/select drive, captured result on a valid/ready handshake. Option: ALU_ISSUE_ACC_EN.
module alu_issue_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [2:0] in_sel,
`ifdef ALU_ISSUE_ACC_EN
  input  logic       in_acc,
`endif
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef ALU_ISSUE_ACC_EN
  localparam int unsigned W = 20;
`else
  localparam int unsigned W = 19;
`endif
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [W-1:0]  head;
  logic [W-1:0]  wr_word;
  logic [7:0]    load_a;

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  // Pop decision uses the registered count: a command pushed this cycle waits one cycle.
  assign pop      = (count != '0) && ((state == IDLE) || ((state == HOLD) && res_ready));
  assign busy     = (count != '0) || (state != IDLE);
  assign head     = mem[rd_ptr];

`ifdef ALU_ISSUE_ACC_EN
  assign wr_word = {in_acc, in_a, in_b, in_sel};
  // res_data is final whenever a pop can occur, so chaining reads it directly.
  assign load_a  = head[19] ? res_data : head[18:11];
`else
  assign wr_word = {in_a, in_b, in_sel};
  assign load_a  = head[18:11];
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a   <= load_a;
            alu_b   <= head[10:3];
            alu_sel <= head[2:0];
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_out;
          res_zero  <= alu_zero;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              alu_a   <= load_a;
              alu_b   <= head[10:3];
              alu_sel <= head[2:0];
              state   <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected results queued at acceptance,
// a negedge monitor pops and compares on each result handshake.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic       clk, rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_sel;
`ifdef ALU_ISSUE_ACC_EN
  logic       in_acc;
`endif
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_zero;
  logic       res_valid, res_ready, res_zero, busy;
  logic [7:0] res_data;

  typedef struct packed {logic [7:0] d; logic z;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] last_res = 8'h00;
  logic       hold_seen = 1'b0;
  logic [8:0] held = '0;

  alu_issue_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
`ifdef ALU_ISSUE_ACC_EN
    .in_acc(in_acc),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .busy(busy)
  );

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    int r;
    case (s)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = int'(a) - int'(b) + 256;
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      3'd5:    r = 255 - int'(a);
      3'd6:    r = int'(a) * 2;
      default: r = int'(a) / 2;
    endcase
    return 8'(r % 256);
  endfunction

  // Stand-in for the combinational ALU that sits between the issue stage ports.
  always_comb begin
    alu_out  = ref_alu(alu_a, alu_b, alu_sel);
    alu_zero = (alu_out == 8'h00);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && !res_ready) begin
        if (hold_seen) chk("res_stable", {23'd0, res_data, res_zero}, {23'd0, held});
        held = {res_data, res_zero};
        hold_seen = 1'b1;
      end else begin
        hold_seen = 1'b0;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {24'd0, res_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_data", {24'd0, res_data}, {24'd0, e.d});
          chk("res_zero", {31'd0, res_zero}, {31'd0, e.z});
        end
      end
    end
  end

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic acc);
    logic [7:0] ea;
    logic [7:0] r;
    bit done = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = s;
`ifdef ALU_ISSUE_ACC_EN
    in_acc = acc;
`endif
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ea = (ACC && acc) ? last_res : a;
        r = ref_alu(ea, b, s);
        exp_q.push_back('{d: r, z: (r == 8'h00)});
        last_res = r;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int pushed;
    bit rnd_done;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; res_ready = 1'b1;
`ifdef ALU_ISSUE_ACC_EN
    in_acc = 1'b0;
`endif
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    chk("rst_res_zero", {31'd0, res_zero}, 32'd0);
    chk("rst_alu_regs", {13'd0, alu_a, alu_b, alu_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Latency: accept at n, load at n+1, result at n+2.
    push_cmd(8'h0F, 8'h01, 3'd0, 1'b0);
    chk("lat_n_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_alu_a", {24'd0, alu_a}, 32'h0F);
    chk("lat_alu_sel", {29'd0, alu_sel}, 32'd0);
    chk("lat_n1_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_valid", {31'd0, res_valid}, 32'd1);
    chk("lat_n2_data", {24'd0, res_data}, 32'h10);
    chk("lat_n2_zero", {31'd0, res_zero}, 32'd0);
    @(posedge clk); #1;
    chk("busy_idle", {31'd0, busy}, 32'd0);

    push_cmd(8'h22, 8'h22, 3'd1, 1'b0);
    drain();

    // Full buffering: DEPTH queued plus one held.
    res_ready = 1'b0;
    push_cmd(8'h01, 8'h01, 3'd0, 1'b0);
    push_cmd(8'h09, 8'h04, 3'd1, 1'b0);
    push_cmd(8'hF0, 8'h3C, 3'd2, 1'b0);
    push_cmd(8'h81, 8'h00, 3'd6, 1'b0);
    push_cmd(8'h81, 8'h00, 3'd7, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain();
    chk("after_full_in_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset during EXEC drops the in-flight command.
    push_cmd(8'hA5, 8'h5A, 3'd4, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_alu_regs", {13'd0, alu_a, alu_b, alu_sel}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    last_res = 8'h00;
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("arst_no_result", {31'd0, res_valid}, 32'd0);
    end

`ifdef ALU_ISSUE_ACC_EN
    push_cmd(8'h05, 8'h03, 3'd0, 1'b0);
    push_cmd(8'hFF, 8'h02, 3'd0, 1'b1);
    drain();
    chk("acc_last", {24'd0, res_data}, 32'h0A);
`endif

    // Random commands with a randomly stalling consumer.
    pushed = 0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          push_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
          pushed++;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !rnd_done; c++) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    chk("rnd_pushed", pushed, 32'd20);
    drain();
    @(posedge clk); #1;
    chk("rnd_busy_end", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
